// File: rtl/split_bus_arbiter.sv
// Round-robin arbiter for a shared serial bus with single-outstanding split transactions.
// Parks a master on split_ack and hands the bus back to it when the split target returns.
module split_bus_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned MAX_HOLD  = 64,
    localparam int unsigned IDX_W    = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] i_m_req,
    output logic [N_MASTERS-1:0] o_m_grant,
    input  logic                 i_split_ack,
    input  logic                 i_split_req,
    output logic                 o_split_grant,
    output logic                 o_split_pending,
    output logic [IDX_W-1:0]     o_split_owner,
    output logic                 o_bus_busy,
    output logic                 o_hold_timeout,
    output logic                 o_split_err
);

    typedef enum logic [1:0] {
        StIdle,
        StMaster,
        StSplitServe
    } state_t;

    localparam logic [N_MASTERS-1:0] ONE = {{(N_MASTERS-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [IDX_W-1:0]     r_cur;
    logic [IDX_W-1:0]     r_last;
    logic [15:0]          r_hold;
    logic [N_MASTERS-1:0] r_m_grant;
    logic                 r_split_grant;
    logic                 r_split_pending;
    logic [IDX_W-1:0]     r_split_owner;
    logic                 r_bus_busy;
    logic                 r_hold_timeout;
    logic                 r_split_err;

    logic [N_MASTERS-1:0] w_eligible;
    logic                 w_found;
    logic [IDX_W-1:0]     w_pick;
    logic [IDX_W-1:0]     w_idx;
    logic [15:0]          w_hold_inc;
    logic                 w_timeout;

    // Round-robin search starting just after the last owner; the parked master is skipped.
    always_comb begin
        w_eligible = i_m_req;
        if (r_split_pending) begin
            w_eligible[r_split_owner] = 1'b0;
        end
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            w_idx = IDX_W'((32'(r_last) + k) % N_MASTERS);
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_hold_inc = (r_hold == 16'hFFFF) ? r_hold : r_hold + 16'd1;
        w_timeout  = (MAX_HOLD != 0) && (32'(w_hold_inc) >= MAX_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= StIdle;
            r_cur           <= '0;
            r_last          <= IDX_W'(N_MASTERS - 1);
            r_hold          <= '0;
            r_m_grant       <= '0;
            r_split_grant   <= 1'b0;
            r_split_pending <= 1'b0;
            r_split_owner   <= '0;
            r_bus_busy      <= 1'b0;
            r_hold_timeout  <= 1'b0;
            r_split_err     <= 1'b0;
        end else begin
            r_hold_timeout <= 1'b0;
            r_split_err    <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (r_split_pending && i_split_req) begin
                        r_state       <= StSplitServe;
                        r_split_grant <= 1'b1;
                        r_m_grant     <= ONE << r_split_owner;
                        r_bus_busy    <= 1'b1;
                    end else if (w_found) begin
                        r_state    <= StMaster;
                        r_cur      <= w_pick;
                        r_m_grant  <= ONE << w_pick;
                        r_bus_busy <= 1'b1;
                        r_hold     <= '0;
                    end
                end
                StMaster: begin
                    r_hold <= w_hold_inc;
                    if (i_split_ack) begin
                        // A second split cannot be tracked: flag it and keep the current owner.
                        if (!r_split_pending) begin
                            r_split_pending <= 1'b1;
                            r_split_owner   <= r_cur;
                            r_m_grant       <= '0;
                            r_bus_busy      <= 1'b0;
                            r_state         <= StIdle;
                        end else begin
                            r_split_err <= 1'b1;
                        end
                    end else if (!i_m_req[r_cur]) begin
                        r_m_grant  <= '0;
                        r_bus_busy <= 1'b0;
                        r_last     <= r_cur;
                        r_state    <= StIdle;
                    end else if (w_timeout) begin
                        r_m_grant      <= '0;
                        r_bus_busy     <= 1'b0;
                        r_hold_timeout <= 1'b1;
                        r_last         <= r_cur;
                        r_state        <= StIdle;
                    end
                end
                StSplitServe: begin
                    if (!i_split_req) begin
                        r_split_grant   <= 1'b0;
                        r_m_grant       <= '0;
                        r_split_pending <= 1'b0;
                        r_bus_busy      <= 1'b0;
                        r_last          <= r_split_owner;
                        r_state         <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_m_grant       = r_m_grant;
    assign o_split_grant   = r_split_grant;
    assign o_split_pending = r_split_pending;
    assign o_split_owner   = r_split_owner;
    assign o_bus_busy      = r_bus_busy;
    assign o_hold_timeout  = r_hold_timeout;
    assign o_split_err     = r_split_err;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Directed bench for split_bus_arbiter (2 masters, 8-cycle watchdog) with an expectation queue.
// Expected vector bits: {m_grant[1:0], split_grant, split_pending, split_owner, busy, timeout, err}.
module tb_split_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] m_req;
    logic [1:0] m_grant;
    logic       split_ack;
    logic       split_req;
    logic       split_grant;
    logic       split_pending;
    logic [0:0] split_owner;
    logic       bus_busy;
    logic       hold_timeout;
    logic       split_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    split_bus_arbiter #(
        .N_MASTERS(2),
        .MAX_HOLD (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_m_req        (m_req),
        .o_m_grant      (m_grant),
        .i_split_ack    (split_ack),
        .i_split_req    (split_req),
        .o_split_grant  (split_grant),
        .o_split_pending(split_pending),
        .o_split_owner  (split_owner),
        .o_bus_busy     (bus_busy),
        .o_hold_timeout (hold_timeout),
        .o_split_err    (split_err)
    );

    // Pops the oldest expectation and compares; split_owner is only meaningful while pending.
    task automatic check_out();
        logic [7:0] e;
        logic [7:0] o;
        logic [7:0] m;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {m_grant, split_grant, split_pending, split_owner, bus_busy, hold_timeout, split_err};
        m = e[4] ? 8'hFF : 8'hF7;
        checks++;
        assert ((o & m) === (e & m))
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", t, o & m, e & m);
        end
    endtask

    task automatic step(input string tag, input logic [1:0] req, input logic ack,
                        input logic sreq, input logic [7:0] exp);
        m_req     = req;
        split_ack = ack;
        split_req = sreq;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_now(input string tag, input logic [7:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        m_req     = 2'b00;
        split_ack = 1'b0;
        split_req = 1'b0;
        #12;
        check_now("reset_state", 8'b00_0_0_0_0_0_0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request, release, idle gap
        step("t1_grant",   2'b01, 1'b0, 1'b0, 8'b01_0_0_0_1_0_0);
        step("t1_release", 2'b00, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0);
        step("t1_idle",    2'b00, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0);

        // Round-robin alternation with a gap between owners
        for (int i = 0; i < 4; i++) step("t2_m1_own", 2'b11, 1'b0, 1'b0, 8'b10_0_0_0_1_0_0);
        step("t2_m1_rel", 2'b01, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0);
        for (int i = 0; i < 4; i++) step("t2_m0_own", 2'b11, 1'b0, 1'b0, 8'b01_0_0_0_1_0_0);
        step("t2_m0_rel", 2'b10, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0);
        step("t2_m1_again", 2'b11, 1'b0, 1'b0, 8'b10_0_0_0_1_0_0);
        step("t2_m1_rel2",  2'b01, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0);
        step("t2_idle",     2'b00, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0);

        // Split on M0; M1 served while M0 stays parked
        step("t3_m0_grant", 2'b01, 1'b0, 1'b0, 8'b01_0_0_0_1_0_0);
        step("t3_split",    2'b11, 1'b1, 1'b0, 8'b00_0_1_0_0_0_0);
        step("t3_m1_grant", 2'b11, 1'b0, 1'b0, 8'b10_0_1_0_1_0_0);
        step("t3_m1_hold",  2'b11, 1'b0, 1'b0, 8'b10_0_1_0_1_0_0);

        // Split return waits for M1 to finish
        step("t4_no_preempt", 2'b11, 1'b0, 1'b1, 8'b10_0_1_0_1_0_0);
        step("t4_m1_rel",     2'b01, 1'b0, 1'b1, 8'b00_0_1_0_0_0_0);
        step("t4_serve",      2'b01, 1'b0, 1'b1, 8'b01_1_1_0_1_0_0);
        step("t4_serve_hold", 2'b01, 1'b0, 1'b1, 8'b01_1_1_0_1_0_0);
        step("t4_done",       2'b01, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0);
        step("t4_idle",       2'b00, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0);

        // Watchdog revokes M1 after 8 cycles, then M0 gets the bus
        step("t5_m1_grant", 2'b11, 1'b0, 1'b0, 8'b10_0_0_0_1_0_0);
        for (int i = 0; i < 7; i++) step("t5_m1_hold", 2'b11, 1'b0, 1'b0, 8'b10_0_0_0_1_0_0);
        step("t5_timeout",  2'b11, 1'b0, 1'b0, 8'b00_0_0_0_0_1_0);
        step("t5_m0_grant", 2'b11, 1'b0, 1'b0, 8'b01_0_0_0_1_0_0);
        step("t5_m0_rel",   2'b10, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0);
        step("t5_idle",     2'b00, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0);

        // Second split_ack while pending, then async reset during split service
        step("t6_m0_grant", 2'b01, 1'b0, 1'b0, 8'b01_0_0_0_1_0_0);
        step("t6_split",    2'b01, 1'b1, 1'b0, 8'b00_0_1_0_0_0_0);
        step("t6_m1_grant", 2'b11, 1'b0, 1'b0, 8'b10_0_1_0_1_0_0);
        step("t6_split_err", 2'b11, 1'b1, 1'b0, 8'b10_0_1_0_1_0_1);
        step("t6_err_clear", 2'b11, 1'b0, 1'b0, 8'b10_0_1_0_1_0_0);
        step("t6_m1_rel",   2'b01, 1'b0, 1'b1, 8'b00_0_1_0_0_0_0);
        step("t6_serve",    2'b01, 1'b0, 1'b1, 8'b01_1_1_0_1_0_0);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("t6_async_reset", 8'b00_0_0_0_0_0_0);
        m_req     = 2'b00;
        split_req = 1'b0;
        @(posedge clk);
        #1;
        check_now("t6_reset_held", 8'b00_0_0_0_0_0_0);
        rst_n = 1'b1;

        // Split owned by M1: owner index 1, M0 served meanwhile
        step("t7_m1_grant", 2'b10, 1'b0, 1'b0, 8'b10_0_0_0_1_0_0);
        step("t7_split",    2'b10, 1'b1, 1'b0, 8'b00_0_1_1_0_0_0);
        step("t7_m0_grant", 2'b11, 1'b0, 1'b0, 8'b01_0_1_1_1_0_0);
        step("t7_m0_rel",   2'b10, 1'b0, 1'b1, 8'b00_0_1_1_0_0_0);
        step("t7_serve",    2'b10, 1'b0, 1'b1, 8'b10_1_1_1_1_0_0);
        step("t7_done",     2'b10, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0);
        step("t7_idle",     2'b00, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
